// File: rtl/sram_bus_pkg.sv
// Shared constants and state encoding for the SRAM bus master.
// Optional WAIT timeout is enabled by defining SRAM_BUS_TIMEOUT_EN.
package sram_bus_pkg;

  // Controller register addresses selecting the transfer direction
  localparam logic [15:0] CTRL_ADDR_READ  = 16'hFFFA;
  localparam logic [15:0] CTRL_ADDR_WRITE = 16'hFFFB;

  localparam int DEF_WAIT_TIMEOUT = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEV  = 3'd1,
    ST_ADDR = 3'd2,
    ST_WAIT = 3'd3,
    ST_DATA = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/sram_bus_master_count_reg.sv
// Up-counter with synchronous clear (priority over enable) and async active-low reset.
module count_reg #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sram_bus_master.sv
// Burst master for an SRAM controller: DEV/ADDR/WAIT/DATA/DONE sequencing of 1..4 word bursts.
// Define SRAM_BUS_TIMEOUT_EN to bound WAIT and report a sticky err on timeout.
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int A_WIDTH      = 16,
  parameter int D_WIDTH      = 16,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic               clk50MHz,
  input  logic               rst_L,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [1:0]         req_len,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               wdata_ready,
  output logic [D_WIDTH-1:0] rdata,
  output logic               rdata_valid,
  output logic               done,
  output logic               err,
  output logic [A_WIDTH-1:0] baddr,
  output logic [1:0]         bburst,
  input  logic               bwait,
  output logic [D_WIDTH-1:0] bdata_out,
  output logic               bdata_oe,
  input  logic [D_WIDTH-1:0] bdata_in
);

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]           len_q, len_d;
  logic                 arm_q, arm_d;
  logic [D_WIDTH-1:0]   rdata_q, rdata_d;
  logic                 rdata_valid_q, rdata_valid_d;
  logic [1:0]           beat;
  logic                 wait_exit;
  logic                 to_hit;

  count_reg #(.W(2)) u_beat_cnt (
    .clk_i  (clk50MHz),
    .rst_ni (rst_L),
    .clr_i  (state_q != ST_DATA),
    .en_i   (state_q == ST_DATA),
    .cnt_o  (beat)
  );

  // WAIT only ends on a low bwait after the controller has shown at least one high cycle
  assign wait_exit = (state_q == ST_WAIT) && arm_q && !bwait;

`ifdef SRAM_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(WAIT_TIMEOUT) + 1;

  logic [TO_W-1:0] to_cnt;
  logic            err_q, err_d;

  count_reg #(.W(TO_W)) u_to_cnt (
    .clk_i  (clk50MHz),
    .rst_ni (rst_L),
    .clr_i  (state_q != ST_WAIT),
    .en_i   (state_q == ST_WAIT),
    .cnt_o  (to_cnt)
  );

  assign to_hit = (state_q == ST_WAIT) && (to_cnt == TO_W'(WAIT_TIMEOUT - 1));

  always_comb begin
    err_d = err_q;
    if (req_valid && (state_q == ST_IDLE)) begin
      err_d = 1'b0;
    end else if (to_hit && !wait_exit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk50MHz or negedge rst_L) begin
    if (!rst_L) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    len_d         = len_q;
    arm_d         = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    req_ready     = 1'b0;
    baddr         = '0;
    bburst        = '0;
    bdata_oe      = 1'b0;
    bdata_out     = '0;
    wdata_ready   = 1'b0;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          len_d   = req_len;
          state_d = ST_DEV;
        end
      end
      ST_DEV: begin
        baddr   = write_q ? A_WIDTH'(CTRL_ADDR_WRITE) : A_WIDTH'(CTRL_ADDR_READ);
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        baddr   = addr_q;
        bburst  = len_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        baddr  = addr_q;
        bburst = len_q;
        arm_d  = arm_q | bwait;
        if (wait_exit) begin
          state_d = ST_DATA;
        end else if (to_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DATA: begin
        baddr  = addr_q;
        bburst = len_q;
        // Writes are purely combinational pass-through, so the client can never stall a beat
        if (write_q) begin
          bdata_oe    = 1'b1;
          bdata_out   = wdata;
          wdata_ready = 1'b1;
        end else begin
          rdata_d       = bdata_in;
          rdata_valid_d = 1'b1;
        end
        if (beat == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50MHz or negedge rst_L) begin
    if (!rst_L) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      arm_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      arm_q         <= arm_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// Scoreboard bench for sram_bus_master: bench plays the SRAM controller and the client.
// Timeout scenario runs only when SRAM_BUS_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_sram_bus_master;

  logic        clk50MHz = 1'b0;
  logic        rst_L    = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr  = '0;
  logic [1:0]  req_len   = '0;
  logic [15:0] wdata     = '0;
  logic        wdata_ready;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic [15:0] baddr;
  logic [1:0]  bburst;
  logic        bwait     = 1'b0;
  logic [15:0] bdata_out;
  logic        bdata_oe;
  logic [15:0] bdata_in  = '0;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [15:0] rq[$];
  logic [15:0] wq[$];

  sram_bus_master #(.A_WIDTH(16), .D_WIDTH(16), .WAIT_TIMEOUT(32)) dut (
    .clk50MHz    (clk50MHz),
    .rst_L       (rst_L),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata       (wdata),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .baddr       (baddr),
    .bburst      (bburst),
    .bwait       (bwait),
    .bdata_out   (bdata_out),
    .bdata_oe    (bdata_oe),
    .bdata_in    (bdata_in)
  );

  always #10 clk50MHz = ~clk50MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50MHz);
    #1;
  endtask

  // Output monitor: consumes scoreboard entries as the DUT produces bus writes and read strobes
  always @(negedge clk50MHz) begin
    if (rst_L) begin
      if (bdata_oe) begin
        chk("wr_ready", wdata_ready, 1);
        if (wq.size() == 0) chk("wr_extra_beat", wq.size(), 1);
        else chk("wr_data", bdata_out, wq.pop_front());
      end
      if (wdata_ready && !bdata_oe) chk("wrdy_without_oe", bdata_oe, 1);
      if (rdata_valid) begin
        if (rq.size() == 0) chk("rd_extra_strobe", rq.size(), 1);
        else chk("rd_data", rdata, rq.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_baddr"}, baddr, 0);
    chk({tag, "_bburst"}, bburst, 0);
    chk({tag, "_oe"}, bdata_oe, 0);
    chk({tag, "_wrdy"}, wdata_ready, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rvld"}, rdata_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // One complete burst. WAIT is driven as: one unarmed low cycle, nwait high cycles, one low exit cycle.
  task automatic run_burst(input logic w, input logic [15:0] addr, input logic [1:0] len,
                           input int nwait, input logic [15:0] base, input bit keep, input int rst_beat);
    int d0;
    d0 = done_cnt;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    req_len   = len;
    chk("idle_rdy", req_ready, 1);
    step();
    req_valid = keep;
    chk("dev_baddr", baddr, w ? 16'hFFFB : 16'hFFFA);
    chk("dev_rdy", req_ready, 0);
    chk("dev_oe", bdata_oe, 0);
    chk("dev_err", err, 0);
    step();
    chk("addr_baddr", baddr, addr);
    chk("addr_bburst", bburst, len);
    chk("addr_rdy", req_ready, 0);
    step();
    bwait = 1'b0;
    chk("wait0_oe", bdata_oe, 0);
    for (int i = 0; i < nwait; i++) begin
      step();
      bwait = 1'b1;
      chk("wait_oe", bdata_oe, 0);
      chk("wait_bburst", bburst, len);
    end
    step();
    bwait = 1'b0;
    chk("wait_exit_oe", bdata_oe, 0);
    for (int b = 0; b <= int'(len); b++) begin
      logic [15:0] v;
      step();
      v = base + 16'(b);
      wdata    = v;
      bdata_in = v;
      if (w) wq.push_back(v);
      else   rq.push_back(v);
      chk("data_bburst", bburst, len);
      chk("data_rdy", req_ready, 0);
      if (!w) chk("rd_data_oe", bdata_oe, 0);
      if (b == rst_beat) begin
        #2 rst_L = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        wq.delete();
        rq.delete();
        step();
        rst_L = 1'b1;
        step();
        chk("rst_rdy_after", req_ready, 1);
        chk("rst_no_done", done_cnt, d0);
        return;
      end
    end
    step();
    chk("done_pulse", done, 1);
    chk("done_oe", bdata_oe, 0);
    chk("done_rdy", req_ready, 0);
    step();
    chk("idle_rdy_after", req_ready, 1);
    chk("idle_done_low", done, 0);
    chk("done_once", done_cnt, d0 + 1);
    chk("rq_left", rq.size(), 0);
    chk("wq_left", wq.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk50MHz);
    #1;
    check_reset_outputs("por");
    rst_L = 1'b1;
    step();
    chk("por_rdy", req_ready, 1);

    run_burst(1'b0, 16'h0040, 2'd3, 3, 16'h00A1, 1'b0, -1);
    run_burst(1'b1, 16'h0100, 2'd0, 1, 16'hBEEF, 1'b0, -1);
    run_burst(1'b1, 16'h1234, 2'd2, 2, 16'h5A00, 1'b0, -1);
    run_burst(1'b0, 16'hABCD, 2'd0, 5, 16'h7700, 1'b0, -1);
    // Request held valid across the whole first burst
    run_burst(1'b0, 16'h0300, 2'd1, 1, 16'h3300, 1'b1, -1);
    run_burst(1'b1, 16'h0400, 2'd3, 2, 16'hC000, 1'b0, -1);
    // Reset during write beat 2
    run_burst(1'b1, 16'h0500, 2'd3, 1, 16'hD000, 1'b0, 2);

`ifdef SRAM_BUS_TIMEOUT_EN
    begin
      int d0;
      d0 = done_cnt;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'h0200;
      req_len   = 2'd1;
      step();
      req_valid = 1'b0;
      chk("to_dev_baddr", baddr, 16'hFFFA);
      step();
      step();
      bwait = 1'b1;
      for (int i = 1; i < 32; i++) begin
        chk("to_wait_done", done, 0);
        step();
      end
      chk("to_c32_done", done, 0);
      chk("to_c32_err", err, 0);
      step();
      chk("to_done", done, 1);
      chk("to_err", err, 1);
      step();
      chk("to_idle_rdy", req_ready, 1);
      chk("to_err_sticky", err, 1);
      chk("to_done_once", done_cnt, d0 + 1);
      repeat (6) step();
      chk("to_err_hold", err, 1);
      bwait = 1'b0;
    end
`endif

    run_burst(1'b0, 16'hFFF0, 2'd2, 1, 16'h1110, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bus_master.md
SRAM_BUS_MASTER -- requirements
Module: sram_bus_master

Interface
REQ-001 Parameter A_WIDTH, default 16, bus/memory address width.
REQ-002 Parameter D_WIDTH, default 16, data word width.
REQ-003 Parameter WAIT_TIMEOUT, default 32, maximum cycles spent in WAIT.
REQ-004 clk50MHz  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_L  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  client request present.
REQ-007 req_ready  out  1  high only in IDLE.
REQ-008 req_write  in  1  1=write burst, 0=read burst.
REQ-009 req_addr  in  A_WIDTH  starting memory address.
REQ-010 req_len  in  2  burst length minus one (1..4 words).
REQ-011 wdata  in  D_WIDTH  write word; must be valid in every write DATA cycle.
REQ-012 wdata_ready  out  1  current wdata is consumed this cycle.
REQ-013 rdata  out  D_WIDTH  captured read word.
REQ-014 rdata_valid  out  1  one-cycle strobe per captured word.
REQ-015 done  out  1  one-cycle pulse at burst end.
REQ-016 err  out  1  sticky WAIT timeout flag; cleared by next accepted request.
REQ-017 baddr  out  A_WIDTH  to controller address bus.
REQ-018 bburst  out  2  to controller burst length.
REQ-019 bwait  in  1  controller latency wait.
REQ-020 bdata_out / bdata_oe / bdata_in  out/out/in  D_WIDTH/1/D_WIDTH  data bus drive, drive enable, sampled data.

Function
REQ-021 States IDLE, DEV, ADDR, WAIT, DATA, DONE; handshake accepted when req_valid && req_ready, latching write, addr, len; IDLE->DEV.
REQ-022 IDLE: baddr=0, bburst=0, bdata_oe=0.
REQ-023 DEV (1 cycle): baddr=CTRL_ADDR_WRITE (16'hFFFB) if write else CTRL_ADDR_READ (16'hFFFA); ->ADDR.
REQ-024 ADDR (1 cycle): baddr=latched addr, bburst=latched len; ->WAIT; bburst held at len through DATA.
REQ-025 WAIT: arm flag set when bwait=1 sampled; leave to DATA on first cycle bwait=0 with arm set; bwait=0 before arming never exits WAIT.
REQ-026 DATA lasts exactly len+1 cycles, counted by a 2-bit beat counter cleared on entry; ->DONE after beat==len.
REQ-027 Write DATA: bdata_oe=1, bdata_out=wdata combinationally, wdata_ready=1 each cycle; no stall possible.
REQ-028 Read DATA: bdata_in registered each cycle into rdata, rdata_valid high the following cycle (latency 1); last strobe coincides with DONE.
REQ-029 DONE (1 cycle): done=1, bdata_oe=0; ->IDLE; req_valid during DEV..DONE ignored.
REQ-030 len=0 yields a single DATA cycle; len=3 yields four.

Reset
REQ-031 rst_L low at any time, including mid-burst: state=IDLE immediately, baddr=0, bburst=0, bdata_oe=0, wdata_ready=0, rdata=0, rdata_valid=0, done=0, err=0, counters cleared; req_ready=1 after release.

Configuration
REQ-032 SRAM_BUS_TIMEOUT_EN defined: WAIT cycle counter; reaching WAIT_TIMEOUT sets err, skips DATA, goes to DONE (done still pulses, no rdata_valid).
REQ-033 SRAM_BUS_TIMEOUT_EN undefined: WAIT is unbounded, err tied 0, no timeout counter.

Structure
REQ-034 Shared package sram_bus_pkg holds CTRL_ADDR_READ, CTRL_ADDR_WRITE, state encoding, default WAIT_TIMEOUT.
REQ-035 Beat and timeout counters instantiate existing count_reg; no other sub-module.

Verification
REQ-036 Read len=3 addr 16'h0040, bwait high 3 cycles: baddr FFFA, 0040; four rdata_valid strobes with bdata_in values A1..A4 in order; done once.
REQ-037 Write len=0 addr 16'h0100, wdata 16'hBEEF: baddr FFFB, 0100; exactly one cycle bdata_oe=1 with bdata_out=BEEF; wdata_ready single pulse.
REQ-038 Back-to-back requests held valid: second accepted only in IDLE after DONE; no overlap of DEV with prior DATA.
REQ-039 rst_L asserted in write DATA beat 2: bdata_oe drops asynchronously, no done, req_ready=1 after release.
REQ-040 With SRAM_BUS_TIMEOUT_EN, bwait stuck high 40 cycles: err=1 and done at WAIT cycle 32; next request clears err.
